// File: rtl/gps_ack_peak_report_pkg.sv
// Shared types and helpers for the GPS acquisition peak reporter.
// Holds the FSM state enum, table entry layout and the correlation metric.
package gps_ack_pkg;

  localparam int unsigned NUM_SATS = 32;
  localparam int unsigned LANES    = 8;
  localparam int unsigned LANE_W   = 3;
  localparam int unsigned SAT_W    = 6;
  localparam int unsigned CP_W     = 10;
  localparam int unsigned DOP_W    = 16;
  // Widest integrator supported; narrower integrators are zero-extended into it.
  localparam int unsigned PEAK_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_UPDATE,
    ST_REPORT
  } state_t;

  typedef struct packed {
    logic        [PEAK_W-1:0] peak;
    logic        [CP_W-1:0]   code_phase;
    logic signed [DOP_W-1:0]  doppler;
  } peak_entry_t;

  // Distance of a mismatch count from the half-scale point of an integ_w-bit integrator.
  function automatic logic [PEAK_W-1:0] metric(input logic [PEAK_W-1:0] integ,
                                               input int unsigned        integ_w);
    logic [PEAK_W-1:0] half;
    half = PEAK_W'(1) << (integ_w - 1);
    return (integ >= half) ? (integ - half) : (half - integ);
  endfunction

endpackage

// File: rtl/gps_ack_peak_report_if.sv
// Correlator-side inputs and allocator-side result stream of the peak reporter.
// master = correlator/allocator environment, slave = gps_ack_peak_report.
interface gps_ack_peak_report_if import gps_ack_pkg::*; #(
  parameter int unsigned INTEG_W = 12
) ();

  logic                                ack_start;
  logic                                corr_complete;
  logic                                search_complete;
  logic        [CP_W-1:0]              code_phase;
  logic signed [DOP_W-1:0]             doppler_omega;
  logic        [LANES-1:0][SAT_W-1:0]  sat;
  logic        [LANES-1:0][INTEG_W-1:0] integrator;

  logic                                res_valid;
  logic                                res_ready;
  logic        [SAT_W-1:0]             res_sat;
  logic                                res_detected;
  logic        [INTEG_W-1:0]           res_peak;
  logic        [CP_W-1:0]              res_code_phase;
  logic signed [DOP_W-1:0]             res_doppler;
  logic                                res_last;
  logic                                busy;
  logic                                overrun_err;

  modport master (
    output ack_start, corr_complete, search_complete, code_phase, doppler_omega,
           sat, integrator, res_ready,
    input  res_valid, res_sat, res_detected, res_peak, res_code_phase, res_doppler,
           res_last, busy, overrun_err
  );

  modport slave (
    input  ack_start, corr_complete, search_complete, code_phase, doppler_omega,
           sat, integrator, res_ready,
    output res_valid, res_sat, res_detected, res_peak, res_code_phase, res_doppler,
           res_last, busy, overrun_err
  );

endinterface

// File: rtl/gps_ack_peak_report_table.sv
// Per-satellite best-peak store: one combinational read port, one write port,
// and a seen vector that clears in a single cycle.
module gps_peak_table #(
  parameter int unsigned NUM_SATS = 32,
  parameter int unsigned IDX_W    = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_clear,
  input  logic                     i_we,
  input  logic [IDX_W-1:0]         i_waddr,
  input  gps_ack_pkg::peak_entry_t i_wdata,
  input  logic [IDX_W-1:0]         i_raddr,
  output gps_ack_pkg::peak_entry_t o_rdata,
  output logic                     o_rseen
);
  import gps_ack_pkg::*;

  peak_entry_t         r_mem [NUM_SATS];
  logic [NUM_SATS-1:0] r_seen;

  // Clear wins over a same-cycle write so an aborted search never leaves a stale entry marked.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_seen <= '0;
      for (int i = 0; i < int'(NUM_SATS); i++) r_mem[i] <= '0;
    end else begin
      if (i_clear)   r_seen <= '0;
      else if (i_we) r_seen[i_waddr] <= 1'b1;
      if (i_we)      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_comb begin
    o_rdata = r_mem[i_raddr];
    o_rseen = r_seen[i_raddr];
  end

endmodule

// File: rtl/gps_ack_peak_report.sv
// Tracks the best correlation peak per PRN over an acquisition search and
// streams one result record per PRN once the search completes.
module gps_ack_peak_report #(
  parameter int unsigned INTEG_W  = 12,
  parameter int unsigned NUM_SATS = gps_ack_pkg::NUM_SATS,
  parameter int unsigned THRESH   = 200
) (
  input  logic                  clk,
  input  logic                  rst,
  gps_ack_peak_report_if.slave  bus
);
  import gps_ack_pkg::*;

  localparam int unsigned IDX_W = (NUM_SATS > 1) ? $clog2(NUM_SATS) : 1;
  localparam int unsigned RPT_W = SAT_W + 1;

  state_t r_state, w_state_nxt;

  logic                            r_cc_d, r_sc_d;
  logic [LANES-1:0][SAT_W-1:0]     r_sat;
  logic [LANES-1:0][INTEG_W-1:0]   r_integ;
  logic        [CP_W-1:0]          r_cp;
  logic signed [DOP_W-1:0]         r_dop;
  logic [LANE_W-1:0]               r_lane;
  logic                            r_pend, r_overrun, r_busy;
  logic [RPT_W-1:0]                r_idx;

  logic                            r_valid, r_last, r_det;
  logic        [SAT_W-1:0]         r_res_sat;
  logic        [INTEG_W-1:0]       r_res_peak;
  logic        [CP_W-1:0]          r_res_cp;
  logic signed [DOP_W-1:0]         r_res_dop;

  logic              w_cap, w_sc, w_hs, w_load, w_we, w_prn_ok, w_lane_last;
  logic              w_cap_go, w_rpt_go, w_ovr_set, w_pend_set;
  logic [SAT_W-1:0]  w_lane_sat;
  logic [PEAK_W-1:0] w_lane_m;
  logic [IDX_W-1:0]  w_raddr;
  peak_entry_t       w_rd, w_wdata;
  logic              w_rseen;

  assign w_cap       = bus.corr_complete & ~r_cc_d;
  assign w_sc        = bus.search_complete & ~r_sc_d;
  assign w_hs        = r_valid & bus.res_ready;
  assign w_lane_last = (r_lane == LANE_W'(LANES - 1));

  // Lane datapath: metric of the current lane against the stored entry for its PRN.
  assign w_lane_sat = r_sat[r_lane];
  assign w_lane_m   = metric(PEAK_W'(r_integ[r_lane]), INTEG_W);
  assign w_prn_ok   = (w_lane_sat != '0) && (32'(w_lane_sat) <= NUM_SATS);
  assign w_raddr    = (r_state == ST_REPORT) ? IDX_W'(r_idx - RPT_W'(1))
                                             : IDX_W'(w_lane_sat - SAT_W'(1));
  assign w_we       = (r_state == ST_UPDATE) && w_prn_ok && !bus.ack_start &&
                      (!w_rseen || (w_lane_m > w_rd.peak));
  assign w_wdata    = '{peak: w_lane_m, code_phase: r_cp, doppler: r_dop};

  // A new record loads when the output slot is empty or being consumed this cycle.
  assign w_load = (r_state == ST_REPORT) && (32'(r_idx) <= NUM_SATS) &&
                  (!r_valid || bus.res_ready) && !bus.ack_start;

  gps_peak_table #(
    .NUM_SATS (NUM_SATS),
    .IDX_W    (IDX_W)
  ) u_table (
    .clk     (clk),
    .rst     (rst),
    .i_clear (bus.ack_start),
    .i_we    (w_we),
    .i_waddr (IDX_W'(w_lane_sat - SAT_W'(1))),
    .i_wdata (w_wdata),
    .i_raddr (w_raddr),
    .o_rdata (w_rd),
    .o_rseen (w_rseen)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cap_go    = 1'b0;
    w_rpt_go    = 1'b0;
    w_ovr_set   = 1'b0;
    w_pend_set  = 1'b0;
    if (bus.ack_start) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_cap) begin
            w_state_nxt = ST_UPDATE;
            w_cap_go    = 1'b1;
            w_pend_set  = w_sc;
          end else if (w_sc) begin
            w_state_nxt = ST_REPORT;
            w_rpt_go    = 1'b1;
          end
        end
        ST_UPDATE: begin
          w_ovr_set  = w_cap;
          w_pend_set = w_sc;
          if (w_lane_last) begin
            if (r_pend || w_sc) begin
              w_state_nxt = ST_REPORT;
              w_rpt_go    = 1'b1;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end
        end
        ST_REPORT: begin
          w_ovr_set = w_cap;
          if (w_hs && r_last) w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Edge detectors, snapshot, lane counter and sticky status.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cc_d    <= 1'b0;
      r_sc_d    <= 1'b0;
      r_sat     <= '0;
      r_integ   <= '0;
      r_cp      <= '0;
      r_dop     <= '0;
      r_lane    <= '0;
      r_pend    <= 1'b0;
      r_overrun <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_cc_d <= bus.corr_complete;
      r_sc_d <= bus.search_complete;
      if (w_cap_go) begin
        r_sat   <= bus.sat;
        r_integ <= bus.integrator;
        r_cp    <= bus.code_phase;
        r_dop   <= bus.doppler_omega;
        r_lane  <= '0;
      end else if (r_state == ST_UPDATE) begin
        r_lane <= r_lane + LANE_W'(1);
      end
      if (bus.ack_start || w_rpt_go) r_pend <= 1'b0;
      else if (w_pend_set)           r_pend <= 1'b1;
      if (bus.ack_start)             r_overrun <= 1'b0;
      else if (w_ovr_set)            r_overrun <= 1'b1;
      r_busy <= (w_state_nxt != ST_IDLE);
    end
  end

  // Result stream; unseen entries report as all-zero, undetected.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx      <= '0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      r_det      <= 1'b0;
      r_res_sat  <= '0;
      r_res_peak <= '0;
      r_res_cp   <= '0;
      r_res_dop  <= '0;
    end else begin
      if (w_rpt_go)    r_idx <= RPT_W'(1);
      else if (w_load) r_idx <= r_idx + RPT_W'(1);
      if (bus.ack_start) begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end else if (w_load) begin
        r_valid    <= 1'b1;
        r_last     <= (32'(r_idx) == NUM_SATS);
        r_res_sat  <= SAT_W'(r_idx);
        r_det      <= w_rseen && (w_rd.peak >= PEAK_W'(THRESH));
        r_res_peak <= w_rseen ? INTEG_W'(w_rd.peak) : '0;
        r_res_cp   <= w_rseen ? w_rd.code_phase : '0;
        r_res_dop  <= w_rseen ? w_rd.doppler : '0;
      end else if (w_hs) begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end
    end
  end

  assign bus.res_valid      = r_valid;
  assign bus.res_sat        = r_res_sat;
  assign bus.res_detected   = r_det;
  assign bus.res_peak       = r_res_peak;
  assign bus.res_code_phase = r_res_cp;
  assign bus.res_doppler    = r_res_dop;
  assign bus.res_last       = r_last;
  assign bus.busy           = r_busy;
  assign bus.overrun_err    = r_overrun;

endmodule

// File: tb/tb_gps_ack_peak_report.sv
// Directed bench for gps_ack_peak_report: hand-computed peak tables checked
// against the streamed records, plus collision, abort and reset scenarios.
module tb_gps_ack_peak_report;
  import gps_ack_pkg::*;

  localparam int unsigned IW = 12;
  localparam int unsigned NS = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  gps_ack_peak_report_if #(.INTEG_W(IW)) bus ();

  gps_ack_peak_report #(.INTEG_W(IW), .NUM_SATS(NS), .THRESH(200)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_err = 0;
  int exp_pk [1:NS];
  int exp_cp [1:NS];
  int exp_dp [1:NS];
  bit exp_det[1:NS];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  function automatic logic [63:0] pack(input bit det, input int pk, input int cp, input int dp);
    return {25'd0, det, pk[11:0], cp[9:0], dp[15:0]};
  endfunction

  task automatic clear_exp();
    for (int i = 1; i <= int'(NS); i++) begin
      exp_pk[i] = 0; exp_cp[i] = 0; exp_dp[i] = 0; exp_det[i] = 1'b0;
    end
  endtask

  task automatic set_exp(input int prn, input int pk, input int cp, input int dp, input bit det);
    exp_pk[prn] = pk; exp_cp[prn] = cp; exp_dp[prn] = dp; exp_det[prn] = det;
  endtask

  task automatic set_lanes();
    bus.sat        = '0;
    bus.integrator = '0;
  endtask

  task automatic ack_pulse();
    bus.ack_start = 1'b1;
    @(posedge clk); #1;
    bus.ack_start = 1'b0;
  endtask

  task automatic chk_reset_outs(input string pfx);
    chk({pfx, "_valid"}, bus.res_valid, 0);
    chk({pfx, "_busy"},  bus.busy, 0);
    chk({pfx, "_ovr"},   bus.overrun_err, 0);
    chk({pfx, "_last"},  bus.res_last, 0);
    chk({pfx, "_det"},   bus.res_detected, 0);
    chk({pfx, "_sat"},   bus.res_sat, 0);
    chk({pfx, "_peak"},  bus.res_peak, 0);
    chk({pfx, "_cp"},    bus.res_code_phase, 0);
    chk({pfx, "_dop"},   bus.res_doppler, 0);
  endtask

  // One capture with busy timing: busy high through C+8, low at C+9.
  task automatic capture(input int cp, input int dp);
    bus.code_phase    = 10'(cp);
    bus.doppler_omega = 16'(dp);
    bus.corr_complete = 1'b1;
    repeat (8) @(posedge clk);
    #1 chk("busy_c8", bus.busy, 1);
    @(posedge clk); #1;
    chk("busy_c9", bus.busy, 0);
    bus.corr_complete = 1'b0;
    @(posedge clk); #1;
  endtask

  // Consume all records; ready pattern 1,0,0 repeating when bp is set.
  task automatic collect(input bit bp);
    int n = 0;
    int cyc = 0;
    while (n < int'(NS) && cyc < 400) begin
      @(negedge clk);
      bus.res_ready = bp ? ((cyc % 3) == 0) : 1'b1;
      cyc++;
      if (bus.res_valid) begin
        chk($sformatf("sat%0d", n + 1), bus.res_sat, n + 1);
        chk($sformatf("rec%0d", n + 1),
            pack(bus.res_detected, bus.res_peak, bus.res_code_phase, bus.res_doppler),
            pack(exp_det[n + 1], exp_pk[n + 1], exp_cp[n + 1], exp_dp[n + 1]));
        chk($sformatf("last%0d", n + 1), bus.res_last, (n + 1) == int'(NS));
        if (bus.res_ready) n++;
      end
    end
    chk("report_count", n, NS);
    @(posedge clk); #1;
    chk("post_valid", bus.res_valid, 0);
    chk("post_busy", bus.busy, 0);
    bus.res_ready = 1'b0;
  endtask

  task automatic do_report(input bit bp);
    bus.search_complete = 1'b1;
    collect(bp);
    bus.search_complete = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit found;
    bus.ack_start = 1'b0; bus.corr_complete = 1'b0; bus.search_complete = 1'b0;
    bus.code_phase = '0; bus.doppler_omega = '0; bus.res_ready = 1'b0;
    set_lanes();
    repeat (3) @(posedge clk);
    #1 chk_reset_outs("reset");
    rst = 1'b1;
    @(posedge clk); #1;

    // Single capture, report latency
    ack_pulse(); clear_exp(); set_lanes();
    bus.sat[0] = 6'd5;  bus.integrator[0] = 12'd100;
    bus.sat[6] = 6'd33; bus.integrator[6] = 12'd0;
    capture(77, 13);
    set_exp(5, 1948, 77, 13, 1'b1);
    bus.search_complete = 1'b1;
    @(posedge clk); #1 chk("rpt_lat_r", bus.res_valid, 0);
    @(posedge clk); #1 chk("rpt_lat_r1", bus.res_valid, 1);
    chk("rpt_first_sat", bus.res_sat, 1);
    collect(1'b0);
    bus.search_complete = 1'b0;
    @(posedge clk); #1;

    // Ties keep the earlier entry, strictly greater replaces
    ack_pulse(); clear_exp();
    set_lanes();
    bus.sat[2] = 6'd3; bus.integrator[2] = 12'd2348;
    bus.sat[1] = 6'd40; bus.integrator[1] = 12'd5;
    capture(10, -5);
    set_lanes(); bus.sat[5] = 6'd3; bus.integrator[5] = 12'd1748;
    capture(20, -6);
    set_lanes(); bus.sat[0] = 6'd3; bus.integrator[0] = 12'd2349;
    capture(30, -7);
    set_exp(3, 301, 30, -7, 1'b1);
    do_report(1'b0);

    ack_pulse(); clear_exp();
    set_lanes();
    bus.sat[2] = 6'd3; bus.integrator[2] = 12'd2348;
    bus.sat[4] = 6'd9; bus.integrator[4] = 12'd2247;
    capture(10, -5);
    set_lanes();
    bus.sat[5] = 6'd3; bus.integrator[5] = 12'd1748;
    bus.sat[4] = 6'd9; bus.integrator[4] = 12'd1898;
    capture(20, -6);
    set_exp(3, 300, 10, -5, 1'b1);
    set_exp(9, 199, 10, -5, 1'b0);
    do_report(1'b0);

    // Threshold at exactly 200, top PRN, backpressured stream
    ack_pulse(); clear_exp(); set_lanes();
    bus.sat[7] = 6'd9;  bus.integrator[7] = 12'd1848;
    bus.sat[6] = 6'd32; bus.integrator[6] = 12'd4095;
    capture(512, 1000);
    set_exp(9, 200, 512, 1000, 1'b1);
    set_exp(32, 2047, 512, 1000, 1'b1);
    do_report(1'b1);

    // Search-complete edge arriving mid-update waits for lane 7
    ack_pulse(); clear_exp(); set_lanes();
    bus.sat[3] = 6'd7; bus.integrator[3] = 12'd0;
    bus.code_phase = 10'd1023; bus.doppler_omega = 16'h8000;
    bus.corr_complete = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (c == 3) bus.search_complete = 1'b1;
      if (c == 5) chk("pend_early", bus.res_valid, 0);
      if (c == 9) begin
        chk("pend_c9_valid", bus.res_valid, 0);
        chk("pend_c9_busy", bus.busy, 1);
      end
      if (c == 10) begin
        chk("pend_c10_valid", bus.res_valid, 1);
        chk("pend_c10_sat", bus.res_sat, 1);
      end
    end
    bus.corr_complete = 1'b0;
    set_exp(7, 2048, 1023, -32768, 1'b1);
    collect(1'b0);
    bus.search_complete = 1'b0;
    @(posedge clk); #1;

    // Overrun: second capture 3 cycles after the first is dropped
    ack_pulse(); clear_exp(); set_lanes();
    bus.sat[1] = 6'd11; bus.integrator[1] = 12'd1000;
    bus.code_phase = 10'd5; bus.doppler_omega = 16'd100;
    bus.corr_complete = 1'b1;
    @(posedge clk); #1 bus.corr_complete = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    bus.integrator[1] = 12'd4000; bus.code_phase = 10'd6;
    bus.corr_complete = 1'b1;
    @(posedge clk); #1 chk("overrun_set", bus.overrun_err, 1);
    repeat (5) @(posedge clk);
    #1 chk("overrun_idle", bus.busy, 0);
    bus.corr_complete = 1'b0;
    @(posedge clk); #1;
    set_exp(11, 1048, 5, 100, 1'b1);
    do_report(1'b0);
    chk("overrun_sticky", bus.overrun_err, 1);
    ack_pulse();
    chk("overrun_clr", bus.overrun_err, 0);

    // Abort mid-report at PRN 12
    clear_exp(); set_lanes();
    bus.sat[0] = 6'd12; bus.integrator[0] = 12'd3000;
    capture(40, 7);
    bus.search_complete = 1'b1;
    bus.res_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (bus.res_valid && bus.res_sat == 6'd12) found = 1'b1;
    end
    chk("abort_reach12", found, 1);
    bus.ack_start = 1'b1;
    bus.res_ready = 1'b0;
    @(posedge clk); #1;
    chk("abort_valid", bus.res_valid, 0);
    bus.ack_start = 1'b0;
    bus.search_complete = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", bus.busy, 0);
    clear_exp();
    do_report(1'b0);

    // Reset asserted mid-update with overrun flagged
    set_lanes();
    bus.sat[0] = 6'd20; bus.integrator[0] = 12'd10;
    bus.corr_complete = 1'b1;
    @(posedge clk); #1 bus.corr_complete = 1'b0;
    @(posedge clk); #1 bus.corr_complete = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    chk("rst_pre_ovr", bus.overrun_err, 1);
    chk("rst_pre_sat", bus.res_sat, 32);
    rst = 1'b0;
    #2 chk_reset_outs("midrst");
    @(posedge clk); #1;
    rst = 1'b1;
    bus.corr_complete = 1'b0;
    @(posedge clk); #1;
    clear_exp();
    do_report(1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
